// File: rtl/read_command_buffer_pkg.sv
// Shared types and defaults for the read command buffer: command line layout,
// buffer status flags and the depth/margin defaults used by read_command_buffer.
package read_command_buffer_pkg;

  localparam int READ_COMMAND_BUFFER_DEPTH  = 16;
  localparam int READ_COMMAND_BUFFER_MARGIN = 4;

  localparam logic [7:0] DATA_READ_CONTROL_ID = 8'h21;

  typedef struct packed {
    logic [7:0]  cu_id;
    logic [7:0]  tag;
    logic [63:0] address;
    logic [15:0] size;
    logic [3:0]  cmd_type;
  } command_payload_t;

  typedef struct packed {
    logic             valid;
    command_payload_t payload;
  } command_buffer_line_t;

  typedef struct packed {
    logic valid;
    logic empty;
    logic alfull;
    logic full;
  } buffer_status_t;

  localparam int PAYLOAD_BITS = $bits(command_payload_t);
  localparam int CMD_BITS     = $bits(command_buffer_line_t);
  localparam int STATUS_BITS  = $bits(buffer_status_t);

  // Status value presented while the buffer holds nothing (also the reset value).
  function automatic buffer_status_t empty_status();
    buffer_status_t s;
    s.valid  = 1'b0;
    s.empty  = 1'b1;
    s.alfull = 1'b0;
    s.full   = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/read_command_buffer_fifo_sync_ram.sv
// Synchronous FIFO storage for read_command_buffer: RAM array, wrapping
// read/write pointers and a registered read-data port. Occupancy is tracked by the caller.
module read_command_buffer_fifo_sync_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [WIDTH-1:0] rd_data_r;

  // Storage array is left unreset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer advance and registered head read.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/read_command_buffer.sv
// Command FIFO between read_engine and the CU arbiter, with backpressure status.
// Optional statistics outputs are enabled by defining READ_COMMAND_BUFFER_STATS_EN.
module read_command_buffer
  import read_command_buffer_pkg::*;
#(
  parameter int         FIFO_DEPTH         = READ_COMMAND_BUFFER_DEPTH,
  parameter int         ALMOST_FULL_MARGIN = READ_COMMAND_BUFFER_MARGIN,
  parameter logic [7:0] CU_READ_CONTROL_ID = DATA_READ_CONTROL_ID
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   enabled_in,
  input  logic [CMD_BITS-1:0]    command_in,
  input  logic                   pop_in,
  output logic [CMD_BITS-1:0]    command_out,
  output logic [STATUS_BITS-1:0] buffer_status_out,
  output logic                   overflow_error_out
`ifdef READ_COMMAND_BUFFER_STATS_EN
  ,
  output logic [31:0]                   push_count_out,
  output logic [31:0]                   pop_count_out,
  output logic [15:0]                   drop_count_out,
  output logic [$clog2(FIFO_DEPTH):0]   max_occupancy_out
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALFULL_CNT = CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  command_buffer_line_t cmd_s;
  command_buffer_line_t line_s;
  command_payload_t     stamped_s;
  command_payload_t     head_s;
  buffer_status_t       status_next_s;
  buffer_status_t       status_r;

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_s;
  logic             empty_s;
  logic             push_req_s;
  logic             push_ok_s;
  logic             push_drop_s;
  logic             pop_ok_s;
  logic             out_valid_r;
  logic             overflow_r;

  assign cmd_s = command_buffer_line_t'(command_in);

  // Push/pop qualification against the pre-edge count; no same-cycle slot reuse or bypass.
  always_comb begin
    full_s      = (count_r == DEPTH_CNT);
    empty_s     = (count_r == {CNT_W{1'b0}});
    push_req_s  = cmd_s.valid & enabled_in;
    push_ok_s   = push_req_s & ~full_s;
    push_drop_s = push_req_s & full_s;
    pop_ok_s    = pop_in & ~empty_s;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // The arbiter sees the CU identity, so it is stamped before the entry is stored.
  always_comb begin
    stamped_s       = cmd_s.payload;
    stamped_s.cu_id = CU_READ_CONTROL_ID;
  end

  // Flags are decoded from the next count so the registered status matches the count register.
  always_comb begin
    status_next_s.empty  = (count_next_s == {CNT_W{1'b0}});
    status_next_s.valid  = ~status_next_s.empty;
    status_next_s.full   = (count_next_s == DEPTH_CNT);
    status_next_s.alfull = (count_next_s >= ALFULL_CNT);
  end

  read_command_buffer_fifo_sync_ram #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (push_ok_s),
    .wr_data (stamped_s),
    .rd_en   (pop_ok_s),
    .rd_data (head_s)
  );

  // Occupancy, output strobe, status and sticky overflow registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      status_r    <= empty_status();
      overflow_r  <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      out_valid_r <= pop_ok_s;
      status_r    <= status_next_s;
      if (push_drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Payload holds its last value between pops; only the valid strobe pulses.
  always_comb begin
    line_s.valid   = out_valid_r;
    line_s.payload = head_s;
  end

  assign command_out        = line_s;
  assign buffer_status_out  = status_r;
  assign overflow_error_out = overflow_r;

`ifdef READ_COMMAND_BUFFER_STATS_EN
  logic [31:0]      push_cnt_r;
  logic [31:0]      pop_cnt_r;
  logic [15:0]      drop_cnt_r;
  logic [CNT_W-1:0] max_occ_r;

  // Saturating event counters and peak occupancy.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      push_cnt_r <= 32'd0;
      pop_cnt_r  <= 32'd0;
      drop_cnt_r <= 16'd0;
      max_occ_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s && (push_cnt_r != {32{1'b1}})) begin
        push_cnt_r <= push_cnt_r + 32'd1;
      end
      if (pop_ok_s && (pop_cnt_r != {32{1'b1}})) begin
        pop_cnt_r <= pop_cnt_r + 32'd1;
      end
      if (push_drop_s && (drop_cnt_r != {16{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
      if (count_next_s > max_occ_r) begin
        max_occ_r <= count_next_s;
      end
    end
  end

  assign push_count_out    = push_cnt_r;
  assign pop_count_out     = pop_cnt_r;
  assign drop_count_out    = drop_cnt_r;
  assign max_occupancy_out = max_occ_r;
`endif

endmodule

// File: tb/tb_read_command_buffer.sv
// Table-driven cycle bench for read_command_buffer (default depth 16, margin 4),
// plus hand-written latency and asynchronous-reset sequences.
module tb_read_command_buffer;
  import read_command_buffer_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic       val;
    logic [7:0] tag;
    logic       pop;
    logic       ov;
    logic [7:0] otag;
    logic       e;
    logic       af;
    logic       f;
    logic       err;
  } vec_t;

  logic                   clock;
  logic                   rst;
  logic                   enabled_in;
  logic [CMD_BITS-1:0]    command_in;
  logic                   pop_in;
  logic [CMD_BITS-1:0]    command_out;
  logic [STATUS_BITS-1:0] buffer_status_out;
  logic                   overflow_error_out;
`ifdef READ_COMMAND_BUFFER_STATS_EN
  logic [31:0] push_count_out;
  logic [31:0] pop_count_out;
  logic [15:0] drop_count_out;
  logic [4:0]  max_occupancy_out;
`endif

  command_buffer_line_t co;
  buffer_status_t       st;
  assign co = command_buffer_line_t'(command_out);
  assign st = buffer_status_t'(buffer_status_out);

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  read_command_buffer dut (
    .clock              (clock),
    .rst                (rst),
    .enabled_in         (enabled_in),
    .command_in         (command_in),
    .pop_in             (pop_in),
    .command_out        (command_out),
    .buffer_status_out  (buffer_status_out),
    .overflow_error_out (overflow_error_out)
`ifdef READ_COMMAND_BUFFER_STATS_EN
    ,
    .push_count_out     (push_count_out),
    .pop_count_out      (pop_count_out),
    .drop_count_out     (drop_count_out),
    .max_occupancy_out  (max_occupancy_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic en, input logic val, input logic [7:0] tag,
                     input logic pop, input logic ov, input logic [7:0] otag, input logic e,
                     input logic af, input logic f, input logic err);
    vec_t v;
    v.rst = r; v.en = en; v.val = val; v.tag = tag; v.pop = pop;
    v.ov = ov; v.otag = otag; v.e = e; v.af = af; v.f = f; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic val, input logic [7:0] tag);
    command_buffer_line_t c;
    c = '0;
    c.valid            = val;
    c.payload.tag      = tag;
    c.payload.cu_id    = 8'hEE;
    c.payload.address  = {32'hCAFE0000, 24'h000000, tag};
    c.payload.size     = 16'h0040;
    c.payload.cmd_type = 4'h3;
    command_in = c;
  endtask

  initial begin
    int cnt;
    int lat;
    rst = 1'b1; enabled_in = 1'b1; pop_in = 1'b0;
    drive(1'b0, 8'd0);

    // Reset with 5 entries stored, then a pop that must yield nothing.
    add(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b1, 1'b1, 8'(20 + i), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Fill tags 0..15: alfull from count 12, full at 16.
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 8'd0, 1'b0, (i + 1) >= 12, (i + 1) == 16, 1'b0);
    // Full: push 99 with pop -> 99 dropped, tag 0 out, count 15, overflow sticky.
    add(1'b0, 1'b1, 1'b1, 8'd99, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int j = 1; j < 16; j++) begin
      cnt = 15 - j;
      add(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'(j), cnt == 0, cnt >= 12, 1'b0, 1'b1);
    end
    add(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    // Empty: push 7 with pop -> no bypass; next pop yields 7; payload then holds.
    add(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // Disabled: valid commands ignored, pops find nothing.
    add(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 1'b1, 8'(30 + i), 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      @(negedge clock);
      rst = vecs[k].rst; enabled_in = vecs[k].en; pop_in = vecs[k].pop;
      drive(vecs[k].val, vecs[k].tag);
      @(posedge clock);
      #1;
      chk("out_valid", k, 64'(co.valid), 64'(vecs[k].ov));
      chk("out_tag", k, 64'(co.payload.tag), 64'(vecs[k].otag));
      chk("empty", k, 64'(st.empty), 64'(vecs[k].e));
      chk("status_valid", k, 64'(st.valid), 64'(!vecs[k].e));
      chk("alfull", k, 64'(st.alfull), 64'(vecs[k].af));
      chk("full", k, 64'(st.full), 64'(vecs[k].f));
      chk("overflow", k, 64'(overflow_error_out), 64'(vecs[k].err));
      if (vecs[k].ov) begin
        chk("cu_id", k, 64'(co.payload.cu_id), 64'(DATA_READ_CONTROL_ID));
        chk("address", k, co.payload.address, {32'hCAFE0000, 24'h000000, vecs[k].otag});
      end
    end

    // Pop-to-valid latency, bounded wait.
    @(negedge clock);
    rst = 1'b0; enabled_in = 1'b1; pop_in = 1'b0;
    drive(1'b1, 8'd5);
    @(negedge clock);
    drive(1'b0, 8'd0);
    pop_in = 1'b1;
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      pop_in = 1'b0;
      lat++;
      if (co.valid) break;
    end
    chk("pop_latency", 1000, 64'(lat), 64'd1);
    chk("latency_tag", 1000, 64'(co.payload.tag), 64'd5);

    // Asynchronous reset away from any clock edge discards stored entries.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b1, 8'(40 + i));
    end
    @(negedge clock);
    drive(1'b0, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_empty", 1001, 64'(st.empty), 64'd1);
    chk("async_status_valid", 1001, 64'(st.valid), 64'd0);
    chk("async_out_valid", 1001, 64'(co.valid), 64'd0);
    @(negedge clock);
    rst = 1'b0;
    pop_in = 1'b1;
    @(posedge clock);
    #1;
    pop_in = 1'b0;
    chk("post_reset_pop", 1002, 64'(co.valid), 64'd0);
    chk("post_reset_empty", 1002, 64'(st.empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
